muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; datapath fixed at 32 bits, register addresses 5 bits.
REQ-002 i_clk  input  1  rising-edge clock.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_start  input  1  request; sampled only while o_ready=1.
REQ-005 i_funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 i_rs1_data  input  32  operand A, from register file read port 1.
REQ-007 i_rs2_data  input  32  operand B, from register file read port 2.
REQ-008 i_rd_adr  input  5  destination register of the request.
REQ-009 i_flush  input  1  synchronous abort of any in-flight operation.
REQ-010 o_ready  output  1  high only in IDLE.
REQ-011 o_valid  output  1  one-cycle result strobe.
REQ-012 o_result  output  32  result; drives register file write data.
REQ-013 o_rd_adr  output  5  captured i_rd_adr; drives register file write address.
REQ-014 o_reg_write  output  1  equals o_valid AND (o_rd_adr != 0); drives register file write enable.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-016 IDLE: at a rising edge with i_start=1 and i_flush=0, SHALL capture both operands, i_funct3 and i_rd_adr, clear the iteration counter, and enter BUSY.
REQ-017 SHALL ignore i_start while in BUSY or DONE; no queuing.
REQ-018 BUSY: SHALL perform exactly one iteration per cycle (shift-add for multiply, restoring shift-subtract for divide) on unsigned magnitudes.
REQ-019 BUSY: after the 32nd iteration, SHALL enter DONE with o_result registered.
REQ-020 DONE: SHALL hold o_valid=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency: o_valid SHALL be high in the cycle after the 32nd rising edge following the accepting edge, for every op including special cases.
REQ-022 Signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-023 Signed results SHALL be formed from magnitudes plus final sign correction.
REQ-024 Result selection:
- MUL returns product[31:0].
- MULH, MULHSU and MULHU return product[63:32].
- DIV and DIVU return the quotient, truncated toward zero.
- REM and REMU return the remainder; the remainder takes the sign of the dividend.
REQ-025 Divide by zero: DIV and DIVU SHALL return 0xFFFFFFFF; REM and REMU SHALL return dividend A.
REQ-026 Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0x00000000.
REQ-027 i_flush=1 at any edge SHALL force IDLE, suppress the pending o_valid, and block acceptance of i_start at that edge.
REQ-028 o_result and o_rd_adr SHALL hold their last values outside DONE; consumers qualify with o_valid.
REQ-029 rd=0: a result to x0 SHALL still pulse o_valid, with o_reg_write=0.

Reset
REQ-030 Asserting i_rst_n low SHALL immediately force IDLE, with o_ready=1, o_valid=0, o_reg_write=0, o_result=0, o_rd_adr=0 and the counter cleared.
REQ-031 Reset asserted mid-operation SHALL discard the operation; no o_valid follows the reset release.
REQ-032 The first i_start SHALL be accepted at the first rising edge after i_rst_n deasserts.

Verification
REQ-033 MUL: A=7, B=0xFFFFFFFD (-3), rd=5 -> o_result=0xFFFFFFEB, o_rd_adr=5, o_reg_write=1, exactly 32 edges after acceptance; o_ready low throughout.
REQ-034 MULHU: A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU with A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-035 Division corners:
- DIV with A=100, B=0 -> 0xFFFFFFFF.
- REM with A=100, B=0 -> 100.
- DIV with A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- DIV with A=-7, B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-036 i_start held high continuously for 3 back-to-back requests -> exactly 3 o_valid pulses, each 34 cycles apart (acceptance to acceptance), each with correct rd.
REQ-037 i_flush at BUSY iteration 10 -> no o_valid; the next request completes normally. A separate run with i_rst_n pulsed low mid-BUSY -> outputs zero immediately and no stale o_valid afterwards.
REQ-038 rd=0 with MUL A=3, B=4 -> o_valid=1, o_result=12, o_reg_write=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add or
// shift-subtract step per cycle on operand magnitudes, 32 steps per op.
module muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [4:0]  i_rd_adr,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd_adr,
    output logic        o_reg_write
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_neg;
    logic        r_dz;
    logic [31:0] r_mb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_result;
    logic [4:0]  r_rd_out;

    logic        w_a_sgn;
    logic        w_b_sgn;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_ma;
    logic [31:0] w_mb;

    logic [32:0] w_madd;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_hi_nx;
    logic [31:0] w_lo_nx;
    logic [63:0] w_prod;
    logic [63:0] w_prod_s;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res;

    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        unique case (i_funct3)
            3'b001, 3'b100, 3'b110: begin
                w_a_sgn = 1'b1;
                w_b_sgn = 1'b1;
            end
            3'b010:  w_a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign w_neg_a = w_a_sgn & i_rs1_data[31];
    assign w_neg_b = w_b_sgn & i_rs2_data[31];
    assign w_ma    = w_neg_a ? (32'd0 - i_rs1_data) : i_rs1_data;
    assign w_mb    = w_neg_b ? (32'd0 - i_rs2_data) : i_rs2_data;

    // r_lo holds |A|: multiplier bits for MUL*, dividend/quotient for DIV*.
    assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : 33'd0);
    assign w_shift = {r_hi, r_lo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_mb});
    assign w_sub   = w_shift[31:0] - r_mb;

    always_comb begin
        if (r_funct3[2]) begin
            w_hi_nx = w_ge ? w_sub : w_shift[31:0];
            w_lo_nx = {r_lo[30:0], w_ge};
        end else begin
            w_hi_nx = w_madd[32:1];
            w_lo_nx = {w_madd[0], r_lo[31:1]};
        end
    end

    assign w_prod   = {w_hi_nx, w_lo_nx};
    assign w_prod_s = r_neg ? (64'd0 - w_prod) : w_prod;
    assign w_quo    = r_neg ? (32'd0 - w_lo_nx) : w_lo_nx;
    assign w_rem    = r_neg ? (32'd0 - w_hi_nx) : w_hi_nx;

    // Signed DIV by zero would otherwise pick up the dividend's sign.
    always_comb begin
        w_res = w_prod_s[31:0];
        unique case (r_funct3)
            3'b000:                 w_res = w_prod_s[31:0];
            3'b001, 3'b010, 3'b011: w_res = w_prod_s[63:32];
            3'b100, 3'b101:         w_res = r_dz ? 32'hFFFF_FFFF : w_quo;
            default:                w_res = w_rem;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_funct3 <= 3'd0;
            r_rd     <= 5'd0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_mb     <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_result <= 32'd0;
            r_rd_out <= 5'd0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state  <= S_BUSY;
                        r_cnt    <= 5'd0;
                        r_funct3 <= i_funct3;
                        r_rd     <= i_rd_adr;
                        r_dz     <= (i_rs2_data == 32'd0);
                        r_neg    <= i_funct3[2] & i_funct3[1]
                                    ? w_neg_a
                                    : (w_neg_a ^ w_neg_b);
                        r_mb     <= w_mb;
                        r_hi     <= 32'd0;
                        r_lo     <= w_ma;
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state  <= S_DONE;
                        r_result <= w_res;
                        r_rd_out <= r_rd;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready     = (r_state == S_IDLE);
    assign o_valid     = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_rd_adr    = r_rd_out;
    assign o_reg_write = o_valid & (r_rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with
// hand-computed results, latency, flush and reset checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd_adr;
    logic        o_reg_write;

    int n_vec = 0;
    int n_bad = 0;

    muldiv_unit dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_funct3    (f3),
        .i_rs1_data  (a),
        .i_rs2_data  (b),
        .i_rd_adr    (rd),
        .i_flush     (flush),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_rd_adr    (o_rd_adr),
        .o_reg_write (o_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Call with the clock low; returns just after a falling edge.
    task automatic run_op(input string tag, input logic [2:0] fn,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] rdv, input logic [31:0] exp);
        int noise;
        noise = 0;
        chk({tag, ".ready_before"}, {31'd0, o_ready}, 32'd1);
        f3 = fn;
        a = av;
        b = bv;
        rd = rdv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'h5A5A_A5A5;
        b = 32'h1234_5678;
        rd = 5'd17;
        noise += int'(o_ready);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k < 32) noise += int'(o_valid) + int'(o_ready);
        end
        chk({tag, ".quiet_busy"}, noise, 32'd0);
        chk({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, ".result"}, o_result, exp);
        chk({tag, ".rd"}, {27'd0, o_rd_adr}, {27'd0, rdv});
        chk({tag, ".wen"}, {31'd0, o_reg_write},
            {31'd0, (rdv != 5'd0)});
        @(posedge clk);
        #1;
        chk({tag, ".valid_after"}, {31'd0, o_valid}, 32'd0);
        chk({tag, ".ready_after"}, {31'd0, o_ready}, 32'd1);
        chk({tag, ".hold"}, o_result, exp);
        @(negedge clk);
    endtask

    logic [31:0] ba [3];
    logic [31:0] bb [3];
    logic [4:0]  brd [3];
    logic [31:0] bexp [3];
    int          acc_t [3];
    int          val_t [3];
    int          n_acc;
    int          nv;
    int          noise;
    logic        was_rdy;

    initial begin
        ba   = '{32'd2, 32'd4, 32'd6};
        bb   = '{32'd3, 32'd5, 32'd7};
        brd  = '{5'd1, 5'd2, 5'd3};
        bexp = '{32'd6, 32'd20, 32'd42};
        acc_t = '{0, 0, 0};
        val_t = '{0, 0, 0};

        repeat (2) @(negedge clk);
        chk("rst.ready", {31'd0, o_ready}, 32'd1);
        chk("rst.valid", {31'd0, o_valid}, 32'd0);
        chk("rst.wen", {31'd0, o_reg_write}, 32'd0);
        chk("rst.result", o_result, 32'd0);
        chk("rst.rd", {27'd0, o_rd_adr}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
               32'hFFFF_FFFE);
        run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
               32'h0000_0000);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8,
               32'hFFFF_FFFF);
        run_op("div0", 3'b100, 32'd100, 32'd0, 5'd9, 32'hFFFF_FFFF);
        run_op("rem0", 3'b110, 32'd100, 32'd0, 5'd10, 32'd100);
        run_op("divov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
               32'h8000_0000);
        run_op("remov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12,
               32'h0000_0000);
        run_op("divneg", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd13,
               32'hFFFF_FFFD);
        run_op("remneg", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd14,
               32'hFFFF_FFFF);
        run_op("divu", 3'b101, 32'hFFFF_FFF0, 32'h10, 5'd15,
               32'h0FFF_FFFF);
        run_op("remu", 3'b111, 32'd100, 32'd7, 5'd16, 32'd2);
        run_op("divu0", 3'b101, 32'd55, 32'd0, 5'd18, 32'hFFFF_FFFF);

        // Three requests with start held high the whole time.
        n_acc = 0;
        nv = 0;
        f3 = 3'b000;
        a = ba[0];
        b = bb[0];
        rd = brd[0];
        start = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            was_rdy = o_ready;
            @(posedge clk);
            #1;
            if (was_rdy && start) begin
                if (n_acc < 3) acc_t[n_acc] = cyc;
                n_acc++;
                if (n_acc < 3) begin
                    a = ba[n_acc];
                    b = bb[n_acc];
                    rd = brd[n_acc];
                end else begin
                    start = 1'b0;
                end
            end
            if (o_valid) begin
                if (nv < 3) begin
                    chk("b2b.rd", {27'd0, o_rd_adr}, {27'd0, brd[nv]});
                    chk("b2b.result", o_result, bexp[nv]);
                    val_t[nv] = cyc;
                end
                nv++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b.accepts", n_acc, 32'd3);
        chk("b2b.pulses", nv, 32'd3);
        chk("b2b.gap1", acc_t[1] - acc_t[0], 32'd34);
        chk("b2b.gap2", acc_t[2] - acc_t[1], 32'd34);
        chk("b2b.lat", val_t[0] - acc_t[0], 32'd32);

        // Flush after ten iterations.
        f3 = 3'b000;
        a = 32'd11;
        b = 32'd13;
        rd = 5'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush.ready", {31'd0, o_ready}, 32'd1);
        noise = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            noise += int'(o_valid);
        end
        chk("flush.no_valid", noise, 32'd0);
        @(negedge clk);
        run_op("post_flush", 3'b101, 32'd100, 32'd7, 5'd6, 32'd14);

        // Reset pulsed in the middle of an operation.
        f3 = 3'b000;
        a = 32'd5;
        b = 32'd6;
        rd = 5'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst.ready", {31'd0, o_ready}, 32'd1);
        chk("mrst.valid", {31'd0, o_valid}, 32'd0);
        chk("mrst.result", o_result, 32'd0);
        chk("mrst.rd", {27'd0, o_rd_adr}, 32'd0);
        chk("mrst.wen", {31'd0, o_reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        noise = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            noise += int'(o_valid);
        end
        chk("mrst.no_stale", noise, 32'd0);
        @(negedge clk);
        run_op("rd0", 3'b000, 32'd3, 32'd4, 5'd0, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
